ami_rd_split: RTL and testbench



---
 rtl/ami_rd_split_if.sv | 65 ++++++
 rtl/ami_rd_split.sv | 151 +++++++++++++++
 tb/tb_ami_rd_split.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ami_rd_split_if.sv
// ami_rd_split bus bundle: user command, AXI AR/R channels,
// user read-data channel and status flags.
interface ami_rd_split_if #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int USR_LW = 16
);
    logic [AXI_IW-1:0] usr_cmd_id;
    logic [AXI_AW-1:0] usr_cmd_addr;
    logic [USR_LW-1:0] usr_cmd_len;
    logic              usr_cmd_valid;
    logic              usr_cmd_ready;

    logic [AXI_IW-1:0] ARID;
    logic [AXI_AW-1:0] ARADDR;
    logic [AXI_LW-1:0] ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;

    logic [AXI_IW-1:0] RID;
    logic [AXI_DW-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    logic [AXI_IW-1:0] usr_rid;
    logic [AXI_DW-1:0] usr_rdata;
    logic [1:0]        usr_rresp;
    logic              usr_rlast;
    logic              usr_rvalid;
    logic              usr_rready;

    logic              busy;
    logic              err_rlast;
    logic              err_rid;

    modport master (
        input  usr_cmd_id, usr_cmd_addr, usr_cmd_len, usr_cmd_valid,
        output usr_cmd_ready,
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output usr_rid, usr_rdata, usr_rresp, usr_rlast, usr_rvalid,
        input  usr_rready,
        output busy, err_rlast, err_rid
    );

    modport slave (
        output usr_cmd_id, usr_cmd_addr, usr_cmd_len, usr_cmd_valid,
        input  usr_cmd_ready,
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  usr_rid, usr_rdata, usr_rresp, usr_rlast, usr_rvalid,
        output usr_rready,
        input  busy, err_rlast, err_rid
    );
endinterface

// File: rtl/ami_rd_split.sv
// AXI read engine: splits one user read command into INCR bursts
// capped at AMI_ML beats and never crossing a 4 KB page.
module ami_rd_split #(
    parameter int AXI_DW = 128,
    parameter int AXI_AW = 32,
    parameter int AXI_IW = 8,
    parameter int AXI_LW = 8,
    parameter int AMI_OD = 4,
    parameter int AMI_ML = 16,
    parameter int USR_LW = 16
) (
    input logic            ACLK,
    input logic            ARESETn,
    ami_rd_split_if.master bus
);
    localparam int BYTES = AXI_DW / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int RW    = USR_LW + 1;
    localparam int BW    = (RW > 13) ? RW : 13;
    localparam int CW    = $clog2(AMI_OD + 1);
    localparam int PW    = (AMI_OD > 1) ? $clog2(AMI_OD) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t state, state_nxt;

    logic [AXI_AW-1:0] cur_addr;
    logic [RW-1:0]     rem;
    logic [AXI_IW-1:0] cid;
    logic [CW-1:0]     ost_cc, ost_nxt;
    logic [AXI_LW-1:0] bcnt;
    logic [PW-1:0]     wr_ptr, rd_ptr;

    logic [AMI_OD-1:0][AXI_LW-1:0] q_len;
    logic [AMI_OD-1:0]             q_fin;

    logic              err_rlast, err_rid;
    logic [12:0]       page_bytes;
    logic [BW-1:0]     page_beats, beats;
    logic [RW-1:0]     rem_nxt;
    logic              cmd_hs, ar_valid, ar_hs;
    logic              ost_nz, exp_last, r_hs, r_done;

    assign cmd_hs     = (state == IDLE) && bus.usr_cmd_valid;
    assign page_bytes = 13'h1000 - {1'b0, cur_addr[11:0]};
    assign page_beats = BW'(page_bytes >> SZ);

    // Burst size: smallest of remaining beats, max burst, page room.
    always_comb begin
        beats = BW'(rem);
        if (beats > BW'(AMI_ML)) beats = BW'(AMI_ML);
        if (beats > page_beats)  beats = page_beats;
    end

    assign rem_nxt  = rem - RW'(beats);
    assign ar_valid = (state == ISSUE) && (ost_cc < CW'(AMI_OD));
    assign ar_hs    = ar_valid && bus.ARREADY;

    assign ost_nz   = (ost_cc != '0);
    assign exp_last = (bcnt == q_len[rd_ptr]);
    assign r_hs     = bus.RVALID && bus.usr_rready && ost_nz;
    assign r_done   = r_hs && exp_last;

    // Outstanding count; a simultaneous issue and burst end cancel out.
    always_comb begin
        ost_nxt = ost_cc;
        unique case ({ar_hs, r_done})
            2'b10:   ost_nxt = ost_cc + CW'(1);
            2'b01:   ost_nxt = ost_cc - CW'(1);
            default: ost_nxt = ost_cc;
        endcase
    end

    // Next-state logic for the command FSM.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.usr_cmd_valid) state_nxt = ISSUE;
            ISSUE:   if (ar_hs && rem_nxt == '0) state_nxt = DRAIN;
            DRAIN:   if (ost_nxt == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, address walk, counters and sticky error flags.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state     <= IDLE;
            cur_addr  <= '0;
            rem       <= '0;
            cid       <= '0;
            ost_cc    <= '0;
            bcnt      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            err_rlast <= 1'b0;
            err_rid   <= 1'b0;
        end else begin
            state  <= state_nxt;
            ost_cc <= ost_nxt;
            if (cmd_hs) begin
                cur_addr  <= bus.usr_cmd_addr & ~AXI_AW'(BYTES - 1);
                rem       <= RW'(bus.usr_cmd_len) + RW'(1);
                cid       <= bus.usr_cmd_id;
                err_rlast <= 1'b0;
                err_rid   <= 1'b0;
            end else if (ar_hs) begin
                cur_addr <= cur_addr + (AXI_AW'(beats) << SZ);
                rem      <= rem_nxt;
            end
            if (ar_hs) begin
                wr_ptr <= (wr_ptr == PW'(AMI_OD - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (r_hs) begin
                bcnt <= exp_last ? '0 : bcnt + AXI_LW'(1);
                if (bus.RLAST != exp_last) err_rlast <= 1'b1;
                if (bus.RID != cid)        err_rid   <= 1'b1;
            end
            if (r_done) begin
                rd_ptr <= (rd_ptr == PW'(AMI_OD - 1)) ? '0 : rd_ptr + PW'(1);
            end
        end
    end

    // Length queue: burst length and final-burst marker per issued AR.
    always_ff @(posedge ACLK) begin
        if (ar_hs) begin
            q_len[wr_ptr] <= AXI_LW'(beats - BW'(1));
            q_fin[wr_ptr] <= (rem_nxt == '0);
        end
    end

    assign bus.usr_cmd_ready = (state == IDLE);
    assign bus.busy          = (state != IDLE);
    assign bus.err_rlast     = err_rlast;
    assign bus.err_rid       = err_rid;

    assign bus.ARID    = cid;
    assign bus.ARADDR  = cur_addr;
    assign bus.ARLEN   = (state == ISSUE) ? AXI_LW'(beats - BW'(1)) : '0;
    assign bus.ARSIZE  = 3'(SZ);
    assign bus.ARBURST = 2'b01;
    assign bus.ARVALID = ar_valid;

    assign bus.RREADY     = bus.usr_rready && ost_nz;
    assign bus.usr_rvalid = bus.RVALID && ost_nz;
    assign bus.usr_rid    = bus.RID;
    assign bus.usr_rdata  = bus.RDATA;
    assign bus.usr_rresp  = bus.RRESP;
    assign bus.usr_rlast  = ost_nz && exp_last && q_fin[rd_ptr];
endmodule

// File: tb/tb_ami_rd_split.sv
// Scoreboard bench for ami_rd_split: directed commands, AXI slave
// model with fault injection, decoupled AR and user-R monitors.
module tb_ami_rd_split;
    localparam int DW  = 128;
    localparam int AW  = 32;
    localparam int IW  = 8;
    localparam int LW  = 8;
    localparam int OD  = 4;
    localparam int ML  = 16;
    localparam int ULW = 16;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    always #5 ACLK = ~ACLK;

    ami_rd_split_if #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW),
                      .AXI_LW(LW), .USR_LW(ULW)) bus ();

    ami_rd_split #(.AXI_DW(DW), .AXI_AW(AW), .AXI_IW(IW), .AXI_LW(LW),
                   .AMI_OD(OD), .AMI_ML(ML), .USR_LW(ULW)) dut (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .bus     (bus.master)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [IW-1:0] id;
    } ar_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] id;
    } r_t;

    ar_t exp_ar[$];
    r_t  exp_r[$];
    ar_t sb[$];
    ar_t ae;
    r_t  re;
    int  bi = 0;

    int npass = 0;
    int ntotal = 0;
    int ar_cnt = 0;
    int coinc = 0;
    bit r_en = 1'b1;
    bit rr_toggle = 1'b0;
    int ar_mode = 0;
    int ar_limit = 0;
    bit bad_last = 1'b0;
    bit bad_rid = 1'b0;

    function automatic void chk(string name, logic [127:0] act,
                                logic [127:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    // Monitors and slave bookkeeping, sampled mid-cycle.
    always @(negedge ACLK) begin
        if (ARESETn) begin
            if (bus.ARVALID && bus.ARREADY && bus.RVALID && bus.RREADY &&
                sb.size() > 0 && bi == int'(sb[0].len))
                coinc++;
            if (bus.usr_rvalid && bus.usr_rready) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                end else begin
                    re = exp_r.pop_front();
                    chk("rdata", bus.usr_rdata, re.data);
                    chk("usr_rlast", bus.usr_rlast, re.last);
                    chk("usr_rid", bus.usr_rid, re.id);
                end
            end
            if (bus.RVALID && bus.RREADY && sb.size() > 0) begin
                if (bi == int'(sb[0].len)) begin
                    void'(sb.pop_front());
                    bi = 0;
                end else begin
                    bi++;
                end
            end
            if (bus.ARVALID && bus.ARREADY) begin
                ar_cnt++;
                if (exp_ar.size() == 0) begin
                    chk("ar_unexpected", 1, 0);
                end else begin
                    ae = exp_ar.pop_front();
                    chk("araddr", bus.ARADDR, ae.addr);
                    chk("arlen", bus.ARLEN, ae.len);
                    chk("arid", bus.ARID, ae.id);
                    chk("arsize_arburst", {bus.ARSIZE, bus.ARBURST},
                        {3'd4, 2'b01});
                end
                sb.push_back('{bus.ARADDR, bus.ARLEN, bus.ARID});
            end
        end
    end

    // Slave and user-side drivers, updated just after each edge.
    always @(posedge ACLK) begin
        #1;
        bus.usr_rready = rr_toggle ? ~bus.usr_rready : 1'b1;
        if (r_en && sb.size() > 0) begin
            bus.RVALID = 1'b1;
            bus.RDATA  = DW'(sb[0].addr) + DW'(bi * 16);
            bus.RLAST  = (bi == int'(sb[0].len)) || (bad_last && bi == 1);
            bus.RID    = sb[0].id ^ IW'(bad_rid);
        end else begin
            bus.RVALID = 1'b0;
            bus.RLAST  = 1'b0;
        end
        unique case (ar_mode)
            1: bus.ARREADY = (sb.size() == 0) ||
                             (bus.RVALID && bus.RLAST && bus.usr_rready);
            2: bus.ARREADY = (ar_cnt < ar_limit);
            default: bus.ARREADY = 1'b1;
        endcase
    end

    task automatic push_ar(input logic [AW-1:0] a, input logic [LW-1:0] l,
                           input logic [IW-1:0] id);
        exp_ar.push_back('{a, l, id});
    endtask

    task automatic send_cmd(input logic [IW-1:0] id,
                            input logic [AW-1:0] addr,
                            input logic [ULW-1:0] len, input bit bad_id);
        bit ok = 1'b0;
        for (int k = 0; k <= int'(len); k++)
            exp_r.push_back('{DW'(addr & ~AW'(15)) + DW'(k * 16),
                              k == int'(len), id ^ IW'(bad_id)});
        @(posedge ACLK);
        #1;
        bus.usr_cmd_id    = id;
        bus.usr_cmd_addr  = addr;
        bus.usr_cmd_len   = len;
        bus.usr_cmd_valid = 1'b1;
        for (int c = 0; c < 500; c++) begin
            @(negedge ACLK);
            if (bus.usr_cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("cmd_accept_timeout", 0, 1);
        @(posedge ACLK);
        #1;
        bus.usr_cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge ACLK);
            if (exp_r.size() == 0 && exp_ar.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("done_in_time", ok, 1);
    endtask

    task automatic reset_checks();
        chk("rst_cmd_ready", bus.usr_cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_arvalid", bus.ARVALID, 0);
        chk("rst_rready", bus.RREADY, 0);
        chk("rst_usr_rvalid", bus.usr_rvalid, 0);
        chk("rst_ar_payload", {bus.ARADDR, bus.ARLEN, bus.ARID}, 0);
        chk("rst_errs", {bus.err_rlast, bus.err_rid}, 0);
    endtask

    initial begin
        bus.usr_cmd_id    = '0;
        bus.usr_cmd_addr  = '0;
        bus.usr_cmd_len   = '0;
        bus.usr_cmd_valid = 1'b0;
        bus.ARREADY       = 1'b0;
        bus.RID           = '0;
        bus.RDATA         = '0;
        bus.RRESP         = 2'b00;
        bus.RLAST         = 1'b0;
        bus.RVALID        = 1'b0;
        bus.usr_rready    = 1'b1;
        repeat (3) @(posedge ACLK);
        #1 ARESETn = 1'b1;
        @(negedge ACLK);
        reset_checks();

        // Single burst, first ARVALID one cycle after accept.
        push_ar(32'h100, 8'd3, 8'h11);
        send_cmd(8'h11, 32'h100, 16'd3, 1'b0);
        @(negedge ACLK);
        chk("arvalid_first", bus.ARVALID, 1);
        chk("busy_active", bus.busy, 1);
        wait_done();
        chk("t1_errs", {bus.err_rlast, bus.err_rid}, 0);

        // 4 KB page split.
        push_ar(32'h0FE0, 8'd1, 8'h22);
        push_ar(32'h1000, 8'd5, 8'h22);
        send_cmd(8'h22, 32'h0FE0, 16'd7, 1'b0);
        wait_done();

        // Outstanding limit with R stalled.
        r_en = 1'b0;
        ar_cnt = 0;
        for (int i = 0; i < 6; i++) push_ar(AW'(i * 256), 8'd15, 8'h44);
        push_ar(32'h600, 8'd3, 8'h44);
        send_cmd(8'h44, 32'h0, 16'd99, 1'b0);
        repeat (30) @(negedge ACLK);
        chk("od_ar_count", ar_cnt, 4);
        chk("od_arvalid_low", bus.ARVALID, 0);
        r_en = 1'b1;
        wait_done();
        chk("od_ar_total", ar_cnt, 7);

        // Early RLAST sets err_rlast, beat count still rules.
        bad_last = 1'b1;
        push_ar(32'h400, 8'd3, 8'h22);
        send_cmd(8'h22, 32'h400, 16'd3, 1'b0);
        wait_done();
        chk("err_rlast_set", bus.err_rlast, 1);
        chk("err_rid_clear", bus.err_rid, 0);
        bad_last = 1'b0;

        // Wrong RID; err_rlast clears on accept.
        bad_rid = 1'b1;
        push_ar(32'h500, 8'd1, 8'h33);
        send_cmd(8'h33, 32'h500, 16'd1, 1'b1);
        @(negedge ACLK);
        chk("err_rlast_cleared", bus.err_rlast, 0);
        wait_done();
        chk("err_rid_set", bus.err_rid, 1);
        bad_rid = 1'b0;

        // Toggling usr_rready and coincident AR / R-last.
        rr_toggle = 1'b1;
        ar_mode = 1;
        coinc = 0;
        for (int i = 0; i < 6; i++)
            push_ar(32'h2000 + AW'(i * 256), 8'd15, 8'h55);
        send_cmd(8'h55, 32'h2000, 16'd95, 1'b0);
        wait_done();
        chk("coincident_seen", coinc > 0, 1);
        chk("t5_errs", {bus.err_rlast, bus.err_rid}, 0);
        rr_toggle = 1'b0;
        ar_mode = 0;

        // Reset with 3 bursts outstanding.
        r_en = 1'b0;
        ar_mode = 2;
        ar_limit = 3;
        ar_cnt = 0;
        for (int i = 0; i < 3; i++)
            push_ar(32'h3000 + AW'(i * 256), 8'd15, 8'h5A);
        send_cmd(8'h5A, 32'h3000, 16'd63, 1'b0);
        for (int c = 0; c < 100 && ar_cnt < 3; c++) @(negedge ACLK);
        repeat (3) @(negedge ACLK);
        chk("rst_ar_outstanding", ar_cnt, 3);
        @(posedge ACLK);
        #1;
        ARESETn = 1'b0;
        r_en = 1'b1;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        @(negedge ACLK);
        reset_checks();
        chk("rst_rvalid_present", bus.RVALID, 1);
        exp_r.delete();
        exp_ar.delete();
        sb.delete();
        bi = 0;
        ar_mode = 0;

        push_ar(32'h0, 8'd0, 8'h66);
        send_cmd(8'h66, 32'h0, 16'd0, 1'b0);
        wait_done();
        chk("post_rst_errs", {bus.err_rlast, bus.err_rid}, 0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
